// File: rtl/memoria_unidade_controle_param_if.sv
// Bus between the memory-game control unit (master) and its datapath (slave):
// ROM address, current round index, LED enable, play-register controls and the comparator result.
interface memoria_unidade_controle_param_if #(
  parameter int AW = 4
);
  logic [AW-1:0] endereco;
  logic [AW-1:0] rodada;
  logic          leds_en;
  logic          zeraR;
  logic          registraR;
  logic          igual;

  modport master (output endereco, rodada, leds_en, zeraR, registraR, input igual);
  modport slave  (input endereco, rodada, leds_en, zeraR, registraR, output igual);
endinterface

// File: rtl/memoria_unidade_controle_param.sv
// Control unit for the memory game: owns position, round, lives and timer counters and sequences
// showing the LED pattern, collecting player moves and reporting the game result.
module memoria_unidade_controle_param #(
  parameter int N_JOGADAS = 16,
  parameter int T_LED     = 1000,
  parameter int T_APAGADO = 250,
  parameter int T_JOGADA  = 3000,
  parameter int VIDAS     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [1:0] nivel,
  input  logic       modo,
  input  logic       tem_jogada,
  memoria_unidade_controle_param_if.master dp,
  output logic [2:0] vidas,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       deu_timeout,
  output logic [3:0] db_estado
);
  localparam int AW    = $clog2(N_JOGADAS);
  localparam int PASSO = N_JOGADAS / 4;
  localparam int T_MAX = (T_LED > T_APAGADO) ? ((T_LED > T_JOGADA) ? T_LED : T_JOGADA)
                                             : ((T_APAGADO > T_JOGADA) ? T_APAGADO : T_JOGADA);
  localparam int TW    = $clog2(T_MAX);

  localparam logic [TW-1:0] T_LED_FIM     = TW'(T_LED - 1);
  localparam logic [TW-1:0] T_APAGADO_FIM = TW'(T_APAGADO - 1);
  localparam logic [TW-1:0] T_JOGADA_FIM  = TW'(T_JOGADA - 1);
  localparam logic [2:0]    VIDAS_INI     = 3'(VIDAS);

  // Encodings double as the debug state code.
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    NOVA_RODADA = 4'h2,
    ESPERA      = 4'h3,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    ERRO_VIDA   = 4'h7,
    FIM_ACERTO  = 4'hA,
    MOSTRA      = 4'hB,
    APAGA       = 4'hC,
    FIM_MOSTRA  = 4'hD,
    FIM_ERRO    = 4'hE,
    FIM_TIMEOUT = 4'hF
  } estado_t;

  estado_t       estado;
  logic [AW-1:0] endereco_q;
  logic [AW-1:0] rodada_q;
  logic [AW-1:0] limite_q;
  logic [2:0]    vidas_q;
  logic [TW-1:0] timer_q;
  logic [AW-1:0] limite_novo;

  // Handshakes: tem_jogada is a one-cycle valid that is only accepted (ready) in ESPERA and is
  // dropped elsewhere; registraR loads the play register and igual is valid one cycle later, in COMPARA.
  always_comb limite_novo = AW'(PASSO * (int'(nivel) + 1) - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= INICIAL;
      endereco_q <= '0;
      rodada_q   <= '0;
      limite_q   <= '0;
      vidas_q    <= '0;
      timer_q    <= '0;
    end else begin
      case (estado)
        INICIAL: if (jogar) estado <= PREPARACAO;
        PREPARACAO: begin
          limite_q <= limite_novo;
          rodada_q <= modo ? limite_novo : '0;
          vidas_q  <= VIDAS_INI;
          estado   <= NOVA_RODADA;
        end
        NOVA_RODADA: begin
          endereco_q <= '0;
          timer_q    <= '0;
          estado     <= MOSTRA;
        end
        MOSTRA: begin
          if (timer_q == T_LED_FIM) begin
            timer_q <= '0;
            estado  <= APAGA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        APAGA: begin
          if (timer_q == T_APAGADO_FIM) begin
            timer_q <= '0;
            if (endereco_q == rodada_q) begin
              estado <= FIM_MOSTRA;
            end else begin
              endereco_q <= endereco_q + AW'(1);
              estado     <= MOSTRA;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        FIM_MOSTRA: begin
          endereco_q <= '0;
          timer_q    <= '0;
          estado     <= ESPERA;
        end
        ESPERA: begin
          // A press on the last allowed cycle still counts as a move.
          if (tem_jogada)                   estado  <= REGISTRA;
          else if (timer_q == T_JOGADA_FIM) estado  <= FIM_TIMEOUT;
          else                              timer_q <= timer_q + TW'(1);
        end
        REGISTRA: estado <= COMPARA;
        COMPARA: begin
          if (!dp.igual) begin
            if (vidas_q > 3'd1) begin
              estado <= ERRO_VIDA;
            end else begin
              vidas_q <= '0;
              estado  <= FIM_ERRO;
            end
          end else if (endereco_q != rodada_q) begin
            estado <= PROXIMO;
          end else if (rodada_q == limite_q) begin
            estado <= FIM_ACERTO;
          end else begin
            rodada_q <= rodada_q + AW'(1);
            estado   <= NOVA_RODADA;
          end
        end
        PROXIMO: begin
          endereco_q <= endereco_q + AW'(1);
          timer_q    <= '0;
          estado     <= ESPERA;
        end
        ERRO_VIDA: begin
          vidas_q <= vidas_q - 3'd1;
          estado  <= NOVA_RODADA;
        end
        FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (jogar) estado <= PREPARACAO;
        default: estado <= INICIAL;
      endcase
    end
  end

  // Moore outputs, decoded only from the state register.
  always_comb begin
    dp.leds_en   = 1'b0;
    dp.zeraR     = 1'b0;
    dp.registraR = 1'b0;
    pronto       = 1'b0;
    ganhou       = 1'b0;
    perdeu       = 1'b0;
    deu_timeout  = 1'b0;
    db_estado    = 4'h9;
    case (estado)
      INICIAL:     begin dp.zeraR = 1'b1; db_estado = 4'h0; end
      PREPARACAO:  begin dp.zeraR = 1'b1; db_estado = 4'h1; end
      NOVA_RODADA: db_estado = 4'h2;
      ESPERA:      db_estado = 4'h3;
      REGISTRA:    begin dp.registraR = 1'b1; db_estado = 4'h4; end
      COMPARA:     db_estado = 4'h5;
      PROXIMO:     db_estado = 4'h6;
      ERRO_VIDA:   begin dp.zeraR = 1'b1; db_estado = 4'h7; end
      MOSTRA:      begin dp.leds_en = 1'b1; db_estado = 4'hB; end
      APAGA:       db_estado = 4'hC;
      FIM_MOSTRA:  db_estado = 4'hD;
      FIM_ACERTO:  begin pronto = 1'b1; ganhou = 1'b1; db_estado = 4'hA; end
      FIM_ERRO:    begin pronto = 1'b1; perdeu = 1'b1; db_estado = 4'hE; end
      FIM_TIMEOUT: begin pronto = 1'b1; perdeu = 1'b1; deu_timeout = 1'b1; db_estado = 4'hF; end
      default:     db_estado = 4'h9;
    endcase
  end

  assign dp.endereco = endereco_q;
  assign dp.rodada   = rodada_q;
  assign vidas       = vidas_q;
endmodule
